register_file_param: RTL and testbench

//  Parametrised 2-read/1-write register file for the processor datapath (successor to the 32x32 file).

---
 rtl/register_file_param.sv | 127 ++++++++++++
 tb/tb_register_file_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// register_file_param: parametrised 2-read/1-write register file with registered reads,
// a sequenced clear-all sweep with BUSY status, and optional forwarding (macro REGFILE_BYPASS_EN).
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic                  CLR,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;
  logic                    sweep_last;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   rd_data1;
  logic [DATA_WIDTH-1:0]   rd_data2;

  assign sweep_last = (sweep_cnt == {ADDR_WIDTH{1'b1}});

  // Next-state logic: CLR is only honoured in IDLE, so a held CLR cannot restart a sweep.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (CLR) next_state = CLEAR;
        else     next_state = IDLE;
      end
      CLEAR: begin
        if (sweep_last) next_state = IDLE;
        else            next_state = CLEAR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single write port, owned by the sweep while clearing.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {ADDR_WIDTH{1'b0}};
    wr_data = {DATA_WIDTH{1'b0}};
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = sweep_cnt;
      wr_data = {DATA_WIDTH{1'b0}};
    end else begin
      wr_en   = WRITE;
      wr_addr = ADDR_W;
      wr_data = DATA_W;
    end
  end

  // Read data selection; forwarding is only reachable in IDLE because rd_accept gates it.
  always_comb begin
    rd_accept = READ && (state == IDLE);
    rd_data1  = mem[ADDR_R1];
    rd_data2  = mem[ADDR_R2];
`ifdef REGFILE_BYPASS_EN
    if (WRITE && (ADDR_W == ADDR_R1)) rd_data1 = DATA_W;
    else                              rd_data1 = mem[ADDR_R1];
    if (WRITE && (ADDR_W == ADDR_R2)) rd_data2 = DATA_W;
    else                              rd_data2 = mem[ADDR_R2];
`endif
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Sweep index walks 0..DEPTH-1 and parks at 0 outside a sweep.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   sweep_cnt <= {ADDR_WIDTH{1'b0}};
    else if ((state == CLEAR) && !sweep_last)  sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
    else                                       sweep_cnt <= {ADDR_WIDTH{1'b0}};
  end

  // Storage array.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {DATA_WIDTH{1'b0}};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read outputs and status; data holds when no read is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_R1  <= {DATA_WIDTH{1'b0}};
      DATA_R2  <= {DATA_WIDTH{1'b0}};
      RD_VALID <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      RD_VALID <= rd_accept;
      BUSY     <= (next_state == CLEAR);
      if (rd_accept) begin
        DATA_R1 <= rd_data1;
        DATA_R2 <= rd_data2;
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param: vector table for the IDLE read/write cases,
// scripted sequences for the clear sweep, reset abort and CLR+WRITE collision.
module tb_register_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, READ, WRITE, CLR;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
  logic [31:0] DATA_W, DATA_R1, DATA_R2;
  logic        RD_VALID, BUSY;

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE), .CLR(CLR),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .RD_VALID(RD_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic        ev;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t         vecs [9];
  logic [63:0]  sb [$];
  logic [31:0]  hold1, hold2;
  int           checks = 0;
  int           errors = 0;
  int           busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected read result, then check after the edge.
  task automatic apply(input logic rd, input logic wr, input logic clr,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] aw,
                       input logic [31:0] dw, input logic ev,
                       input logic [31:0] e1, input logic [31:0] e2, input string tag);
    logic [63:0] exp;
    READ = rd; WRITE = wr; CLR = clr;
    ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
    if (ev) sb.push_back({e1, e2});
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0; CLR = 1'b0;
    chk({tag, " rd_valid"}, {31'd0, RD_VALID}, {31'd0, ev});
    if (ev) begin
      if (sb.size() == 0) begin
        chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        hold1 = exp[63:32];
        hold2 = exp[31:0];
      end
    end
    chk({tag, " data_r1"}, DATA_R1, hold1);
    chk({tag, " data_r2"}, DATA_R2, hold2);
  endtask

  function automatic vec_t mkv(logic rd, logic wr, logic [4:0] a1, logic [4:0] a2,
                               logic [4:0] aw, logic [31:0] dw, logic ev,
                               logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a1 = a1; v.a2 = a2; v.aw = aw; v.dw = dw;
    v.ev = ev; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  initial begin
    vecs[0] = mkv(1'b1, 1'b0, 5'd3,  5'd31, 5'd0,  32'h0,        1'b1, 32'h0, 32'h0);
    vecs[1] = mkv(1'b0, 1'b1, 5'd0,  5'd0,  5'd7,  32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    vecs[2] = mkv(1'b1, 1'b0, 5'd7,  5'd7,  5'd0,  32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[3] = mkv(1'b0, 1'b0, 5'd7,  5'd7,  5'd0,  32'h0,        1'b0, 32'h0, 32'h0);
    vecs[4] = mkv(1'b0, 1'b1, 5'd0,  5'd0,  5'd5,  32'h11111111, 1'b0, 32'h0, 32'h0);
    vecs[5] = mkv(1'b1, 1'b1, 5'd5,  5'd7,  5'd5,  32'h22222222, 1'b1,
                  BYP ? 32'h22222222 : 32'h11111111, 32'hDEADBEEF);
    vecs[6] = mkv(1'b1, 1'b0, 5'd5,  5'd5,  5'd0,  32'h0,        1'b1, 32'h22222222, 32'h22222222);
    vecs[7] = mkv(1'b1, 1'b1, 5'd0,  5'd31, 5'd31, 32'hCAFEF00D, 1'b1,
                  32'h0, BYP ? 32'hCAFEF00D : 32'h0);
    vecs[8] = mkv(1'b1, 1'b0, 5'd31, 5'd31, 5'd0,  32'h0,        1'b1, 32'hCAFEF00D, 32'hCAFEF00D);

    RST = 1'b1; READ = 1'b0; WRITE = 1'b0; CLR = 1'b0;
    ADDR_R1 = 5'd0; ADDR_R2 = 5'd0; ADDR_W = 5'd0; DATA_W = 32'h0;
    hold1 = 32'h0; hold2 = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset data_r1", DATA_R1, 32'h0);
    chk("reset data_r2", DATA_R2, 32'h0);
    chk("reset rd_valid", {31'd0, RD_VALID}, 32'd0);
    chk("reset busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK) RST = 1'b0;

    for (int i = 0; i < 9; i++)
      apply(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].a1, vecs[i].a2, vecs[i].aw, vecs[i].dw,
            vecs[i].ev, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));

    // Fill every entry with its index, spot-check, then sweep.
    for (int i = 0; i < 32; i++)
      apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i), 1'b0, 32'h0, 32'h0, "fill");
    apply(1'b1, 1'b0, 1'b0, 5'd13, 5'd30, 5'd0, 32'h0, 1'b1, 32'd13, 32'd30, "fill rd");
    apply(1'b1, 1'b0, 1'b1, 5'd4, 5'd31, 5'd0, 32'h0, 1'b1, 32'd4, 32'd31, "clr+rd");
    chk("sweep busy rise", {31'd0, BUSY}, 32'd1);
    busy_cnt = BUSY ? 1 : 0;
    for (int c = 0; c < 64 && BUSY; c++) begin
      if (c == 0)
        apply(1'b1, 1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, "busy wr/rd");
      else if (c == 5)
        apply(1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, "busy clr");
      else
        apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, "busy idle");
      if (BUSY) busy_cnt++;
    end
    chk("sweep busy cycles", 32'(busy_cnt), 32'd32);
    for (int i = 0; i < 16; i++)
      apply(1'b1, 1'b0, 1'b0, 5'(i), 5'(i + 16), 5'd0, 32'h0, 1'b1, 32'h0, 32'h0,
            $sformatf("post sweep %0d", i));

    // Reset in the middle of a sweep.
    apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd20, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, "wr20");
    apply(1'b1, 1'b0, 1'b0, 5'd20, 5'd20, 5'd0, 32'h0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, "rd20");
    apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, "clr2");
    repeat (10) apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, "sweep2");
    #2 RST = 1'b1;
    #1;
    chk("abort busy", {31'd0, BUSY}, 32'd0);
    chk("abort rd_valid", {31'd0, RD_VALID}, 32'd0);
    chk("abort data_r1", DATA_R1, 32'h0);
    chk("abort data_r2", DATA_R2, 32'h0);
    hold1 = 32'h0; hold2 = 32'h0;
    @(negedge CLK) RST = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 5'd20, 5'd0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, "rst rd20");
    apply(1'b1, 1'b1, 1'b0, 5'd20, 5'd20, 5'd20, 32'h5A5A5A5A, 1'b1,
          BYP ? 32'h5A5A5A5A : 32'h0, BYP ? 32'h5A5A5A5A : 32'h0, "rst wr+rd20");
    apply(1'b1, 1'b0, 1'b0, 5'd20, 5'd20, 5'd0, 32'h0, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, "rd20 new");
    chk("post abort busy", {31'd0, BUSY}, 32'd0);

    // CLR and WRITE on the same edge: the sweep wins in the end.
    apply(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678, 1'b0, 32'h0, 32'h0, "clr+wr0");
    for (int c = 0; c < 64 && BUSY; c++)
      apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, "sweep3");
    chk("sweep3 done", {31'd0, BUSY}, 32'd0);
    apply(1'b1, 1'b0, 1'b0, 5'd0, 5'd20, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, "rd0 after sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
